// File: rtl/prbs_pkg.sv
// Shared constants and types for the 16-bit PRBS checker:
// word width, Fibonacci LFSR taps, state encoding and default thresholds.
package prbs_pkg;

  localparam int unsigned PRBS_W = 16;

  // x^16 + x^14 + x^13 + x^11 + 1, expressed as bit positions of the current word
  localparam int unsigned TAP_A = 15;
  localparam int unsigned TAP_B = 13;
  localparam int unsigned TAP_C = 12;
  localparam int unsigned TAP_D = 10;

  localparam int unsigned LOCK_CNT_DEF = 4;
  localparam int unsigned LOSS_CNT_DEF = 3;

  // Wide enough for thresholds up to 15
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/lfsr_step.sv
// One shift step of the 16-bit Fibonacci LFSR: shifts left, feedback enters at bit 0.
module lfsr_step
  import prbs_pkg::*;
(
  input  logic [PRBS_W-1:0] v_i,
  output logic [PRBS_W-1:0] v_o
);

  assign v_o = {v_i[PRBS_W-2:0], v_i[TAP_A] ^ v_i[TAP_B] ^ v_i[TAP_C] ^ v_i[TAP_D]};

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: searches for LOCK_CNT consecutive correctly predicted words, then
// flywheels the LFSR and counts mispredictions until LOSS_CNT consecutive misses.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF,
  parameter int unsigned LOSS_CNT = LOSS_CNT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PRBS_W-1:0] i_data,
  input  logic              i_vld,
  input  logic              i_clear,
  output logic              o_locked,
  output logic              o_err,
  output logic [PRBS_W-1:0] o_err_cnt
);

  localparam logic [CNT_W:0] LOCK_TGT = LOCK_CNT[CNT_W:0];
  localparam logic [CNT_W:0] LOSS_TGT = LOSS_CNT[CNT_W:0];

  state_e              state_q, state_d;
  logic [PRBS_W-1:0]   expected_q, expected_d;
  logic                seeded_q, seeded_d;
  logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic [PRBS_W-1:0]   err_cnt_q, err_cnt_d;

  logic [PRBS_W-1:0]   seed_pred;
  logic [PRBS_W-1:0]   fly_pred;
  logic [CNT_W:0]      match_inc;
  logic [CNT_W:0]      miss_inc;
  logic                search_hit;
  logic                locked_hit;

  lfsr_step u_seed_step (
    .v_i (i_data),
    .v_o (seed_pred)
  );

  lfsr_step u_fly_step (
    .v_i (expected_q),
    .v_o (fly_pred)
  );

  assign match_inc  = {1'b0, match_cnt_q} + (CNT_W+1)'(1);
  assign miss_inc   = {1'b0, miss_cnt_q} + (CNT_W+1)'(1);
  // A zero word is the LFSR lock-up value: never a seed, never a match
  assign search_hit = seeded_q && (i_data != '0) && (i_data == expected_q);
  assign locked_hit = (i_data == expected_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SEARCH;
      expected_q  <= '0;
      seeded_q    <= 1'b0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      seeded_q    <= seeded_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    seeded_d    = seeded_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (i_vld) begin
      unique case (state_q)
        ST_SEARCH: begin
          expected_d = seed_pred;
          seeded_d   = (i_data != '0);
          if (!search_hit) begin
            match_cnt_d = '0;
          end else if (match_inc == LOCK_TGT) begin
            state_d     = ST_LOCKED;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
          end else begin
            match_cnt_d = match_inc[CNT_W-1:0];
          end
        end
        ST_LOCKED: begin
          if (locked_hit) begin
            expected_d = fly_pred;
            miss_cnt_d = '0;
          end else if (miss_inc == LOSS_TGT) begin
            // Losing lock: the offending word becomes the new search seed
            state_d     = ST_SEARCH;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
            expected_d  = seed_pred;
            seeded_d    = (i_data != '0);
          end else begin
            expected_d = fly_pred;
            miss_cnt_d = miss_inc[CNT_W-1:0];
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_comb begin
    locked_d  = (state_d == ST_LOCKED);
    err_d     = i_vld && (state_q == ST_LOCKED) && !locked_hit;
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + PRBS_W'(1);
    end
    if (i_clear) begin
      err_cnt_d = '0;
    end
  end

  assign o_locked  = locked_q;
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;

endmodule
